// File: rtl/dead_time_gen.sv
// Two-channel complementary gate driver with programmable dead time and latched fault trip.
// Each channel inserts dead_time cycles with both drives low whenever its PWM demand changes side.
module dead_time_gen #(
  parameter int DT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [DT_W-1:0] dead_time,
  input  logic            pwm_a,
  input  logic            pwm_b,
  input  logic            fault_n,
  input  logic            fault_clr,
  output logic            a_hi,
  output logic            a_lo,
  output logic            b_hi,
  output logic            b_lo,
  output logic            fault_flag
);

  typedef enum logic [2:0] {
    SAFE,
    LO,
    DT_TO_HI,
    HI,
    DT_TO_LO
  } state_t;

  logic [1:0] pwm;
  logic [1:0] hi;
  logic [1:0] lo;
  logic       trip;
  logic       dt_zero;

  assign pwm     = {pwm_b, pwm_a};
  assign trip    = !fault_n || fault_flag;
  assign dt_zero = (dead_time == '0);

  // A fresh trip wins over a clear request arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_flag <= 1'b0;
    end else if (!fault_n) begin
      fault_flag <= 1'b1;
    end else if (fault_clr) begin
      fault_flag <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    state_t          state;
    logic [DT_W-1:0] cnt;
    logic            hi_reg;
    logic            lo_reg;

    // Outputs are registered alongside the state, so they never decode to hi=lo=1.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= SAFE;
        cnt    <= '0;
        hi_reg <= 1'b0;
        lo_reg <= 1'b0;
      end else if (trip || !enable) begin
        state  <= SAFE;
        hi_reg <= 1'b0;
        lo_reg <= 1'b0;
      end else begin
        case (state)
          SAFE: begin
            if (dt_zero) begin
              state  <= pwm[gi] ? HI : LO;
              hi_reg <= pwm[gi];
              lo_reg <= !pwm[gi];
            end else begin
              state  <= pwm[gi] ? DT_TO_HI : DT_TO_LO;
              cnt    <= dead_time;
              hi_reg <= 1'b0;
              lo_reg <= 1'b0;
            end
          end
          LO: begin
            if (pwm[gi]) begin
              lo_reg <= 1'b0;
              if (dt_zero) begin
                state  <= HI;
                hi_reg <= 1'b1;
              end else begin
                state <= DT_TO_HI;
                cnt   <= dead_time;
              end
            end
          end
          DT_TO_HI: begin
            if (!pwm[gi]) begin
              state  <= LO;
              lo_reg <= 1'b1;
            end else if (cnt == DT_W'(1)) begin
              state  <= HI;
              hi_reg <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HI: begin
            if (!pwm[gi]) begin
              hi_reg <= 1'b0;
              if (dt_zero) begin
                state  <= LO;
                lo_reg <= 1'b1;
              end else begin
                state <= DT_TO_LO;
                cnt   <= dead_time;
              end
            end
          end
          DT_TO_LO: begin
            if (pwm[gi]) begin
              state  <= HI;
              hi_reg <= 1'b1;
            end else if (cnt == DT_W'(1)) begin
              state  <= LO;
              lo_reg <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state  <= SAFE;
            hi_reg <= 1'b0;
            lo_reg <= 1'b0;
          end
        endcase
      end
    end

    assign hi[gi] = hi_reg;
    assign lo[gi] = lo_reg;
  end

  assign a_hi = hi[0];
  assign a_lo = lo[0];
  assign b_hi = hi[1];
  assign b_lo = lo[1];

endmodule
